mux_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one 8:1 enable-gated mux datapath among 8 requesters.
- Generates the 3-bit select and the active-low enable that drive the mux.
- Registers the selected data bit and issues a one-hot grant back to the requesters.
- Bounds each requester's tenure under contention so that no requester starves.

---
 rtl/mux_rr_scheduler_if.sv | 20 ++
 rtl/mux_rr_scheduler.sv | 111 +++++++++++
 tb/tb_mux_rr_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mux_rr_scheduler_if.sv
// rtl/mux_rr_scheduler_if.sv - request/grant and mux datapath bundle for mux_rr_scheduler
interface mux_rr_scheduler_if;
    logic [7:0] req;
    logic [7:0] i;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       en_n;
    logic       y;
    logic       y_vld;

    modport master (
        output req, i,
        input  gnt, sel, en_n, y, y_vld
    );

    modport slave (
        input  req, i,
        output gnt, sel, en_n, y, y_vld
    );
endinterface

// File: rtl/mux_rr_scheduler.sv
// rtl/mux_rr_scheduler.sv - round-robin owner scheduler for a shared 8:1 enable-gated mux
// Optional urgent requester 0 (preemption): define MUX_SCHED_PRIO0_EN.
module mux_rr_scheduler #(
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_rr_scheduler_if.slave   bus
);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state;
    logic [2:0]        last;
    logic [HOLD_W-1:0] hold_cnt;

    logic [7:0] mask;
    logic [2:0] win;
    logic [2:0] cand;
    logic       win_found;
    logic       owner_req;
    logic       hold_done;
    logic       rotate_ok;
    logic       do_grant;
    logic       go_idle;
    logic [2:0] grant_idx;

    // gnt is zero in IDLE, so one mask serves both states and excludes the owner in BUSY
    assign mask      = bus.req & ~bus.gnt;
    assign owner_req = bus.req[bus.sel];
    assign hold_done = (hold_cnt == HOLD_W'(MAX_HOLD));

`ifdef MUX_SCHED_PRIO0_EN
    assign rotate_ok = (bus.sel != 3'd0);
`else
    assign rotate_ok = 1'b1;
`endif

    always_comb begin
        win       = 3'd0;
        cand      = 3'd0;
        win_found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cand = last + 3'd1 + 3'(k);
            if (!win_found && mask[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        do_grant  = 1'b0;
        go_idle   = 1'b0;
        grant_idx = win;
        if (state == IDLE) begin
            do_grant = win_found;
        end else if (!owner_req) begin
            do_grant = win_found;
            go_idle  = !win_found;
        end else if (hold_done && win_found && rotate_ok) begin
            do_grant = 1'b1;
        end
`ifdef MUX_SCHED_PRIO0_EN
        if (bus.req[0] && !(state == BUSY && bus.sel == 3'd0)) begin
            do_grant  = 1'b1;
            go_idle   = 1'b0;
            grant_idx = 3'd0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 3'd7;
            hold_cnt  <= '0;
            bus.gnt   <= 8'h00;
            bus.sel   <= 3'd0;
            bus.en_n  <= 1'b1;
            bus.y     <= 1'b0;
            bus.y_vld <= 1'b0;
        end else begin
            bus.y     <= bus.en_n ? 1'b0 : bus.i[bus.sel];
            bus.y_vld <= ~bus.en_n;
            if (do_grant) begin
                state    <= BUSY;
                bus.gnt  <= 8'd1 << grant_idx;
                bus.sel  <= grant_idx;
                bus.en_n <= 1'b0;
                last     <= grant_idx;
                hold_cnt <= HOLD_W'(1);
            end else if (go_idle) begin
                // sel deliberately keeps the last owner's index
                state    <= IDLE;
                bus.gnt  <= 8'h00;
                bus.en_n <= 1'b1;
            end else if (state == BUSY && !hold_done) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.gnt));
    a_en_matches_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        bus.en_n == (bus.gnt == 8'h00));
    a_sel_matches_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        !bus.en_n |-> (bus.gnt == (8'd1 << bus.sel)));
endmodule

// File: tb/tb_mux_rr_scheduler.sv
// tb/tb_mux_rr_scheduler.sv - directed vector bench for mux_rr_scheduler (MAX_HOLD=4)
module tb_mux_rr_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;

    mux_rr_scheduler_if bus();

    mux_rr_scheduler #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [7:0] i;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       en_n;
        logic       y;
        logic       y_vld;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [7:0] gnt, input logic [2:0] sel,
                         input logic en_n, input logic y, input logic y_vld);
        logic [13:0] got;
        logic [13:0] exp;
        got = {bus.gnt, bus.sel, bus.en_n, bus.y, bus.y_vld};
        exp = {gnt, sel, en_n, y, y_vld};
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got gnt=%h sel=%0d en_n=%b y=%b y_vld=%b, want gnt=%h sel=%0d en_n=%b y=%b y_vld=%b",
                     name, bus.gnt, bus.sel, bus.en_n, bus.y, bus.y_vld, gnt, sel, en_n, y, y_vld);
        end
    endtask

    task automatic step(input logic [7:0] req, input logic [7:0] i);
        bus.req = req;
        bus.i   = i;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //                 req    i      gnt    sel   en_n  y     y_vld
        tbl.push_back(vec_t'{8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{8'h10, 8'h10, 8'h10, 3'd4, 1'b0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{8'h10, 8'h10, 8'h10, 3'd4, 1'b0, 1'b1, 1'b1});
        tbl.push_back(vec_t'{8'h10, 8'h10, 8'h10, 3'd4, 1'b0, 1'b1, 1'b1});
        tbl.push_back(vec_t'{8'h10, 8'h10, 8'h10, 3'd4, 1'b0, 1'b1, 1'b1});
        tbl.push_back(vec_t'{8'h10, 8'h10, 8'h10, 3'd4, 1'b0, 1'b1, 1'b1});
        tbl.push_back(vec_t'{8'h00, 8'h10, 8'h00, 3'd4, 1'b1, 1'b1, 1'b1});
        tbl.push_back(vec_t'{8'h00, 8'h10, 8'h00, 3'd4, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{8'h81, 8'h80, 8'h80, 3'd7, 1'b0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{8'h81, 8'h80, 8'h80, 3'd7, 1'b0, 1'b1, 1'b1});
        tbl.push_back(vec_t'{8'h81, 8'h80, 8'h80, 3'd7, 1'b0, 1'b1, 1'b1});
        tbl.push_back(vec_t'{8'h81, 8'h80, 8'h80, 3'd7, 1'b0, 1'b1, 1'b1});
        tbl.push_back(vec_t'{8'h81, 8'h80, 8'h01, 3'd0, 1'b0, 1'b1, 1'b1});
        tbl.push_back(vec_t'{8'h81, 8'h80, 8'h01, 3'd0, 1'b0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{8'h81, 8'h80, 8'h01, 3'd0, 1'b0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{8'h81, 8'h80, 8'h01, 3'd0, 1'b0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{8'h81, 8'h80, 8'h80, 3'd7, 1'b0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{8'h81, 8'h80, 8'h80, 3'd7, 1'b0, 1'b1, 1'b1});
        tbl.push_back(vec_t'{8'h04, 8'h24, 8'h04, 3'd2, 1'b0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{8'h04, 8'h24, 8'h04, 3'd2, 1'b0, 1'b1, 1'b1});
        tbl.push_back(vec_t'{8'h20, 8'h24, 8'h20, 3'd5, 1'b0, 1'b1, 1'b1});
        tbl.push_back(vec_t'{8'h20, 8'h24, 8'h20, 3'd5, 1'b0, 1'b1, 1'b1});
        tbl.push_back(vec_t'{8'h00, 8'h24, 8'h00, 3'd5, 1'b1, 1'b1, 1'b1});
        tbl.push_back(vec_t'{8'h00, 8'h24, 8'h00, 3'd5, 1'b1, 1'b0, 1'b0});

        bus.req = 8'h00;
        bus.i   = 8'h00;
        #12;
        check("reset", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[n]) begin
            step(tbl[n].req, tbl[n].i);
            check($sformatf("vec%0d", n), tbl[n].gnt, tbl[n].sel, tbl[n].en_n, tbl[n].y, tbl[n].y_vld);
        end

        // Asynchronous reset in the middle of a tenure, then restart from index 0
        step(8'hFF, 8'h00);
        check("all_req_grant", 8'h40, 3'd6, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'hFF, 8'h00);
        check("post_reset_first", 8'h01, 3'd0, 1'b0, 1'b0, 1'b0);

        // Owner 3 in tenure while requester 0 asks for the mux
        step(8'h08, 8'h00);
        check("owner3_grant", 8'h08, 3'd3, 1'b0, 1'b0, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            step(8'h09, 8'h00);
`ifdef MUX_SCHED_PRIO0_EN
            check($sformatf("prio0_c%0d", c), 8'h01, 3'd0, 1'b0, 1'b0, 1'b1);
`else
            if (c < 4)
                check($sformatf("rr0_wait_c%0d", c), 8'h08, 3'd3, 1'b0, 1'b0, 1'b1);
            else
                check($sformatf("rr0_wait_c%0d", c), 8'h01, 3'd0, 1'b0, 1'b0, 1'b1);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
